// File: rtl/muldiv_pkg.sv
`default_nettype none
// muldiv_pkg: shared op codes, sequencer states and default unit latencies.
// Rev 1.0
package muldiv_pkg;

   localparam logic [2:0] OP_MULT = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b001;
   localparam logic [2:0] OP_MTHI = 3'b010;
   localparam logic [2:0] OP_MTLO = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN_MUL = 2'd1,
      ST_RUN_DIV = 2'd2
   } state_t;

   localparam int DEF_DIV_CYCLES  = 33;
   localparam int DEF_MULT_CYCLES = 33;
   localparam int DEF_CNT_W       = 6;

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_latency_counter.sv
`default_nettype none
// latency_counter: loadable down-counter that parks at zero and flags it.
// Rev 1.0
module latency_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// muldiv_ctrl: sequences the external multiply/divide units and owns the
// architectural HI/LO registers. Rev 1.0
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        op_ready,
   input  logic        flush,
   input  logic        rd_req,
   output logic        stall,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mul_start,
   output logic        div_start,
   input  logic [31:0] mul_hi,
   input  logic [31:0] mul_lo,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   input  logic        div_zero_in,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_t           state, state_nxt;
   logic             accept;
   logic             complete;
   logic             cnt_load;
   logic             cnt_clear;
   logic [CNT_W-1:0] cnt_load_val;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;

   assign op_ready = (state == ST_IDLE);
   assign busy     = ~op_ready;
   assign stall    = rd_req && busy;
   assign accept   = op_valid && op_ready && !flush;

   latency_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (busy),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_clear    = 1'b0;
      complete     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && (op_code == OP_MULT)) begin
               state_nxt    = ST_RUN_MUL;
               cnt_load     = 1'b1;
               cnt_load_val = MUL_LOAD;
            end else if (accept && (op_code == OP_DIV)) begin
               state_nxt    = ST_RUN_DIV;
               cnt_load     = 1'b1;
               cnt_load_val = DIV_LOAD;
            end
         end
         ST_RUN_MUL, ST_RUN_DIV: begin
            // An abort takes priority over a completion landing on the same edge.
            if (flush) begin
               state_nxt = ST_IDLE;
               cnt_clear = 1'b1;
            end else if (cnt_zero) begin
               state_nxt = ST_IDLE;
               complete  = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         unit_a       <= '0;
         unit_b       <= '0;
         hi_out       <= '0;
         lo_out       <= '0;
         mul_start    <= 1'b0;
         div_start    <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
      end else begin
         mul_start    <= accept && (op_code == OP_MULT);
         div_start    <= accept && (op_code == OP_DIV);
         done         <= complete;
         div_zero_exc <= complete && (state == ST_RUN_DIV) && div_zero_in;
         if (accept && ((op_code == OP_MULT) || (op_code == OP_DIV))) begin
            unit_a <= op_a;
            unit_b <= op_b;
         end
         if (accept && (op_code == OP_MTHI)) begin
            hi_out <= op_a;
         end
         if (accept && (op_code == OP_MTLO)) begin
            lo_out <= op_a;
         end
         if (complete && (state == ST_RUN_MUL)) begin
            hi_out <= mul_hi;
            lo_out <= mul_lo;
         end
         // A divide by zero leaves HI/LO untouched; only the exception reports it.
         if (complete && (state == ST_RUN_DIV) && !div_zero_in) begin
            hi_out <= div_hi;
            lo_out <= div_lo;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// tb_muldiv_ctrl: scoreboard bench with behavioural unit models and a
// queue of expected completions checked by an independent monitor.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int DIV_CYCLES  = 33;
   localparam int MULT_CYCLES = 33;
   localparam int CNT_W       = 6;

   logic        clk = 1'b0;
   logic        reset, op_valid, flush, rd_req, div_zero_in;
   logic [2:0]  op_code;
   logic [31:0] op_a, op_b, mul_hi, mul_lo, div_hi, div_lo;
   logic        op_ready, stall, mul_start, div_start, busy, done, div_zero_exc;
   logic [31:0] unit_a, unit_b, hi_out, lo_out;

   always #5 clk = ~clk;

   muldiv_ctrl #(
      .DIV_CYCLES(DIV_CYCLES), .MULT_CYCLES(MULT_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .flush(flush),
      .rd_req(rd_req), .stall(stall), .unit_a(unit_a), .unit_b(unit_b),
      .mul_start(mul_start), .div_start(div_start), .mul_hi(mul_hi),
      .mul_lo(mul_lo), .div_hi(div_hi), .div_lo(div_lo),
      .div_zero_in(div_zero_in), .hi_out(hi_out), .lo_out(lo_out),
      .busy(busy), .done(done), .div_zero_exc(div_zero_exc)
   );

   typedef struct {
      int          acc;
      int          done_c;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        exc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
   endfunction

   // {remainder, quotient}, computed wide so the -2^31 / -1 case is well defined.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint qt, rm;
      if (b == 32'd0) return 64'd0;
      qt = longint'($signed(a)) / longint'($signed(b));
      rm = longint'($signed(a)) % longint'($signed(b));
      return {rm[31:0], qt[31:0]};
   endfunction

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      rd_req = 1'b0;
      forever begin
         @(negedge clk);
         rd_req = 1'($urandom_range(0, 1));
      end
   end

   // Unit models: results are valid only in the last cycle before the commit edge.
   initial begin
      int          ukind;
      int          age;
      logic [31:0] ua, ub;
      logic [63:0] r;
      ukind = 0; age = 0; ua = '0; ub = '0;
      mul_hi = '0; mul_lo = '0; div_hi = '0; div_lo = '0; div_zero_in = 1'b0;
      forever begin
         @(negedge clk);
         if (mul_start === 1'b1) begin
            ukind = 1; age = 0; ua = unit_a; ub = unit_b;
         end else if (div_start === 1'b1) begin
            ukind = 2; age = 0; ua = unit_a; ub = unit_b;
         end else begin
            age++;
         end
         r = ref_mult(ua, ub);
         mul_hi = (ukind == 1 && age == MULT_CYCLES - 1) ? r[63:32] : $urandom;
         mul_lo = (ukind == 1 && age == MULT_CYCLES - 1) ? r[31:0]  : $urandom;
         r = ref_div(ua, ub);
         div_hi = (ukind == 2 && age == DIV_CYCLES - 1) ? r[63:32] : $urandom;
         div_lo = (ukind == 2 && age == DIV_CYCLES - 1) ? r[31:0]  : $urandom;
         div_zero_in = (ukind == 2 && age == DIV_CYCLES - 1) ? (ub == 32'd0)
                                                             : 1'($urandom_range(0, 1));
      end
   end

   // Monitor: expected busy/stall window and every done pulse against the queue.
   initial begin
      exp_t e;
      bit   busy_exp;
      forever begin
         @(negedge clk);
         #1;
         if (reset !== 1'b1) begin
            busy_exp = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].done_c);
            chk(busy === busy_exp, "busy", 64'(busy), 64'(busy_exp));
            chk(stall === (rd_req && busy_exp), "stall", 64'(stall), 64'(rd_req && busy_exp));
            if (done === 1'b1) begin
               if (q.size() == 0) begin
                  chk(1'b0, "done_unexpected", 64'd1, 64'd0);
               end else begin
                  e = q.pop_front();
                  chk(cyc == e.done_c, "done_cycle", 64'(cyc), 64'(e.done_c));
                  chk(hi_out === e.hi, "hi_commit", 64'(hi_out), 64'(e.hi));
                  chk(lo_out === e.lo, "lo_commit", 64'(lo_out), 64'(e.lo));
                  chk(div_zero_exc === e.exc, "div_zero_exc", 64'(div_zero_exc), 64'(e.exc));
               end
            end else begin
               if (div_zero_exc !== 1'b0)
                  chk(1'b0, "exc_without_done", 64'(div_zero_exc), 64'd0);
               if (q.size() > 0 && cyc >= q[0].done_c) begin
                  chk(1'b0, "done_missing", 64'd0, 64'd1);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   // Called just after a falling edge; returns just after the falling edge of the accept cycle.
   task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int acc);
      int          n;
      logic [63:0] r;
      op_valid = 1'b1; op_code = code; op_a = a; op_b = b; flush = 1'b0;
      n = 0;
      while (op_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (op_ready !== 1'b1) begin
         chk(1'b0, "accept_timeout", 64'd0, 64'd1);
         op_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      case (code)
         OP_MULT: begin
            r = ref_mult(a, b);
            q.push_back('{acc, acc + MULT_CYCLES, r[63:32], r[31:0], 1'b0});
            m_hi = r[63:32]; m_lo = r[31:0];
         end
         OP_DIV: begin
            if (b == 32'd0) begin
               q.push_back('{acc, acc + DIV_CYCLES, m_hi, m_lo, 1'b1});
            end else begin
               r = ref_div(a, b);
               q.push_back('{acc, acc + DIV_CYCLES, r[63:32], r[31:0], 1'b0});
               m_hi = r[63:32]; m_lo = r[31:0];
            end
         end
         OP_MTHI: m_hi = a;
         OP_MTLO: m_lo = a;
         default: ;
      endcase
      @(negedge clk);
      op_valid = 1'b0; op_code = 3'($urandom); op_a = $urandom; op_b = $urandom;
      if (code == OP_MTHI) chk(hi_out === a, "mthi_visible", 64'(hi_out), 64'(a));
      if (code == OP_MTLO) chk(lo_out === a, "mtlo_visible", 64'(lo_out), 64'(a));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk(q.size() == 0, "drain", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          acc, acc2, f;
      logic [31:0] s_hi, s_lo, b;
      logic [2:0]  code;
      reset = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk(hi_out === 32'd0 && lo_out === 32'd0, "reset_hilo", {hi_out, lo_out}, 64'd0);
      chk(unit_a === 32'd0 && unit_b === 32'd0, "reset_unit", {unit_a, unit_b}, 64'd0);
      chk({mul_start, div_start, done, div_zero_exc, busy} === 5'd0, "reset_pulses",
          64'({mul_start, div_start, done, div_zero_exc, busy}), 64'd0);
      chk(op_ready === 1'b1, "reset_ready", 64'(op_ready), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rd_req) begin
            chk(stall === 1'b0, "idle_stall", 64'(stall), 64'd0);
            break;
         end
      end
      @(negedge clk);

      // Signed divide 7 / -2.
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, acc);
      chk(div_start === 1'b1, "div_start_first", 64'(div_start), 64'd1);
      chk(unit_a === 32'd7 && unit_b === 32'hFFFF_FFFE, "unit_operands",
          {unit_a, unit_b}, {32'd7, 32'hFFFF_FFFE});
      @(negedge clk);
      chk(div_start === 1'b0, "div_start_single", 64'(div_start), 64'd0);
      drain();
      chk(hi_out === 32'd1 && lo_out === 32'hFFFF_FFFD, "div_result",
          {hi_out, lo_out}, {32'd1, 32'hFFFF_FFFD});
      chk(unit_a === 32'd7 && unit_b === 32'hFFFF_FFFE, "unit_hold",
          {unit_a, unit_b}, {32'd7, 32'hFFFF_FFFE});

      // Divide by zero leaves preloaded HI/LO intact.
      issue(OP_MTHI, 32'hAAAA_0000, $urandom, acc);
      issue(OP_MTLO, 32'h0000_5555, $urandom, acc);
      issue(OP_DIV, $urandom, 32'd0, acc);
      drain();
      chk(hi_out === 32'hAAAA_0000 && lo_out === 32'h0000_5555, "divzero_hilo",
          {hi_out, lo_out}, {32'hAAAA_0000, 32'h0000_5555});

      // Flush a MULT ten cycles in, then restart immediately.
      s_hi = m_hi; s_lo = m_lo;
      issue(OP_MULT, $urandom, $urandom, acc);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      f = cyc;
      @(negedge clk);
      flush = 1'b0;
      void'(q.pop_back());
      m_hi = s_hi; m_lo = s_lo;
      chk(op_ready === 1'b1, "flush_idle", 64'(op_ready), 64'd1);
      chk(hi_out === s_hi && lo_out === s_lo, "flush_hilo", {hi_out, lo_out}, {s_hi, s_lo});
      issue(OP_MULT, $urandom, $urandom, acc);
      chk(acc == f + 2, "flush_reaccept", 64'(acc), 64'(f + 2));
      drain();

      // DIV then MULT back to back.
      issue(OP_DIV, $urandom, 32'd13, acc);
      issue(OP_MULT, $urandom, $urandom, acc2);
      chk(acc2 == acc + DIV_CYCLES + 1, "b2b_accept", 64'(acc2), 64'(acc + DIV_CYCLES + 1));
      chk(mul_start === 1'b1, "b2b_mul_start", 64'(mul_start), 64'd1);
      drain();

      // Reset in the middle of a DIV.
      issue(OP_DIV, $urandom, 32'd5, acc);
      repeat (19) @(negedge clk);
      reset = 1'b1;
      q.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      chk(hi_out === 32'd0 && lo_out === 32'd0, "midreset_hilo", {hi_out, lo_out}, 64'd0);
      chk(busy === 1'b0 && op_ready === 1'b1, "midreset_idle", 64'(busy), 64'd0);
      repeat (45) @(negedge clk);

      // Random mix including NOP codes and zero divisors.
      for (int i = 0; i < 25; i++) begin
         code = 3'($urandom_range(0, 5));
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         issue(code, $urandom, b, acc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      chk(hi_out === m_hi && lo_out === m_lo, "final_hilo", {hi_out, lo_out}, {m_hi, m_lo});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the iterative multiply and divide units in the MIPS datapath. It accepts MULT/DIV/MTHI/MTLO operations from the main control unit and holds the operands stable for the units. It pulses the unit start line and counts the fixed unit latency, then commits the results into the architectural HI/LO registers. It stalls MFHI/MFLO reads while an operation is in flight and reports divide-by-zero as a one-cycle exception pulse.

## Interface
- DIV_CYCLES, 33, cycles from div_start to valid div_hi/div_lo
- MULT_CYCLES, 33, cycles from mul_start to valid mul_hi/mul_lo
- CNT_W, 6, latency counter width; must hold max(DIV_CYCLES, MULT_CYCLES)-1

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op_valid  in  1  operation request
- op_code  in  3  000 MULT, 001 DIV, 010 MTHI, 011 MTLO, others NOP
- op_a, op_b  in  32 each  operands; op_a is dividend/multiplicand and MTHI/MTLO source
- op_ready  out  1  high when state is IDLE
- flush  in  1  abort in-flight operation
- rd_req  in  1  MFHI/MFLO in decode
- stall  out  1  rd_req && state != IDLE (combinational)
- unit_a, unit_b  out  32 each  registered operands to both units
- mul_start  out  1  one-cycle pulse to multiplier
- div_start  out  1  one-cycle pulse to divider (div_control)
- mul_hi, mul_lo  in  32 each  multiplier results
- div_hi, div_lo  in  32 each  divider remainder/quotient
- div_zero_in  in  1  divider divide-by-zero flag
- hi_out, lo_out  out  32 each  architectural HI/LO
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after commit or abort-free completion
- div_zero_exc  out  1  one-cycle pulse on DIV by zero

## Operation
- Reset: state IDLE, counter 0. hi_out, lo_out, unit_a and unit_b are 0. All pulses, busy and stall are 0.
- States: IDLE, RUN_MUL, RUN_DIV.
- Accept: edge with op_valid && op_ready && !flush.
- MULT/DIV accept: latch op_a/op_b into unit_a/unit_b, load counter with CYCLES-1, and enter RUN_MUL or RUN_DIV. The matching start pulse is high for the first RUN cycle only.
- MTHI/MTLO accept: write op_a to hi_out/lo_out at the acceptance edge. Remain IDLE, no done pulse.
- NOP codes: accepted, no state change.
- RUN: counter decrements each edge.
- Edge where counter==0: capture mul_hi/mul_lo or div_hi/div_lo into hi_out/lo_out, go IDLE, and pulse done.
- DIV with div_zero_in high at the completion edge: HI/LO unchanged, and div_zero_exc and done pulse together.
- unit_a/unit_b hold their values until the next MULT/DIV acceptance.
- flush in RUN: go IDLE at that edge with no HI/LO write, no done pulse, and counter cleared.
- flush in IDLE: blocks acceptance and has no other effect.
- Flush and completion in the same cycle: flush wins.
- Reset mid-operation: same as the reset values above. The units share the same reset line.

## Timing
- Accept at edge E0; start pulse during cycle E0→E1.
- HI/LO valid after edge E0+CYCLES; done and op_ready are high in that cycle.
- A back-to-back op can be accepted at edge E0+CYCLES+1. busy is high for exactly CYCLES cycles.
- MFHI in the done cycle sees the new HI with no stall.
- MTHI/MTLO: value visible on hi_out/lo_out one cycle after acceptance.

## Structure
- Package muldiv_pkg holds:
  - op_code localparams OP_MULT, OP_DIV, OP_MTHI, OP_MTLO;
  - state encoding ST_IDLE, ST_RUN_MUL, ST_RUN_DIV;
  - default latency constants.
- Sub-module latency_counter: loadable down-counter with zero flag, parameterised by CNT_W.
- Units are instantiated by the parent datapath, not inside this block.

## Test plan
- Reset then idle: all outputs 0, op_ready=1. rd_req=1 → stall=0.
- DIV, op_a=7, op_b=-2, divider model returns hi=1, lo=0xFFFFFFFD:
  - div_start high one cycle;
  - busy 33 cycles; stall high whenever rd_req during busy;
  - then hi_out=1, lo_out=0xFFFFFFFD, done pulse.
- DIV, op_b=0, div_zero_in=1:
  - after 33 cycles div_zero_exc=1 and done=1;
  - hi_out/lo_out keep their prior values (preload via MTHI 0xAAAA0000, MTLO 0x5555).
- MULT accepted, flush asserted at cycle 10: IDLE next cycle, no done, HI/LO unchanged. A new MULT is accepted the following cycle.
- Back-to-back: DIV then MULT offered continuously. The MULT is accepted in the DIV done cycle and its mul_start follows immediately.
- reset asserted mid-DIV at cycle 20: next cycle HI/LO=0, busy=0. No done or div_zero_exc afterwards.
